// File: rtl/dual_priority_decoder_pkg.sv
// Shared types and default widths for the dual priority encoder/decoder pair.
// Encoder and decoder sides must agree on these defaults.
package dual_prio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_INPUT_WIDTH  = 8;
  localparam int DEF_OUTPUT_WIDTH = 3;
  localparam int DEF_BEAT_W       = 8;

endpackage

// File: rtl/dual_priority_decoder_dec.sv
// Index-to-one-hot decoder, purely combinational (zero latency, no flow control).
// INPUT_WIDTH must equal 2**OUTPUT_WIDTH, so every index maps to a real bit.
module dual_priority_decoder_dec #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 3
) (
  input  logic [OUTPUT_WIDTH-1:0] idx,
  output logic [INPUT_WIDTH-1:0]  onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/dual_priority_decoder.sv
// Rebuilds a request bitmap from (priority1, priority2) index beats and flags malformed frames.
// Result registered 1 cycle after the last beat and held with in_ready=0 until out_ready.
module dual_priority_decoder
  import dual_prio_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int BEAT_W       = DEF_BEAT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OUTPUT_WIDTH-1:0] in_idx1,
  input  logic                    in_idx1_v,
  input  logic [OUTPUT_WIDTH-1:0] in_idx2,
  input  logic                    in_idx2_v,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INPUT_WIDTH-1:0]  out_mask,
  output logic [BEAT_W-1:0]       out_beats,
  output logic                    out_err
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  state_t                 state;
  state_t                 state_n;
  logic [INPUT_WIDTH-1:0] mask;
  logic [INPUT_WIDTH-1:0] mask_n;
  logic [INPUT_WIDTH-1:0] oh1;
  logic [INPUT_WIDTH-1:0] oh2;
  logic [INPUT_WIDTH-1:0] d1;
  logic [INPUT_WIDTH-1:0] d2;
  logic [INPUT_WIDTH-1:0] new_bits;
  logic [BEAT_W-1:0]      beats;
  logic [BEAT_W-1:0]      beats_n;
  logic                   err;
  logic                   err_n;
  logic                   beat_err;
  logic                   accept;

  dual_priority_decoder_dec #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_dec1 (
    .idx   (in_idx1),
    .onehot(oh1)
  );

  dual_priority_decoder_dec #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_dec2 (
    .idx   (in_idx2),
    .onehot(oh2)
  );

  // No input/output overlap: the result slot doubles as the only stall point.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  assign d1       = in_idx1_v ? oh1 : '0;
  assign d2       = in_idx2_v ? oh2 : '0;
  assign new_bits = d1 | d2;
  assign mask_n   = mask | new_bits;

  // Orphan priority2, inverted/equal ordering, or a bit repeated within the frame.
  assign beat_err = (in_idx2_v && !in_idx1_v)
                 || (in_idx1_v && in_idx2_v && (in_idx2 >= in_idx1))
                 || ((new_bits & mask) != '0);
  assign err_n    = err | beat_err;
  assign beats_n  = (beats == BEAT_MAX) ? beats : beats + 1'b1;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_n = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= '0;
      beats     <= '0;
      err       <= 1'b0;
      out_mask  <= '0;
      out_beats <= '0;
      out_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (in_last) begin
          out_mask  <= mask_n;
          out_beats <= beats_n;
          out_err   <= err_n;
          mask      <= '0;
          beats     <= '0;
          err       <= 1'b0;
        end else begin
          mask  <= mask_n;
          beats <= beats_n;
          err   <= err_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_priority_decoder.sv
// Directed plus randomized frames against a set-based reference model; two DUTs share stimulus
// (default widths and BEAT_W=2) so saturation is observed alongside normal counting.
module tb_dual_priority_decoder;

  localparam int IW = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_ready2;
  logic [OW-1:0] in_idx1;
  logic          in_idx1_v;
  logic [OW-1:0] in_idx2;
  logic          in_idx2_v;
  logic          in_last;
  logic          out_valid;
  logic          out_valid2;
  logic          out_ready;
  logic [IW-1:0] out_mask;
  logic [IW-1:0] out_mask2;
  logic [7:0]    out_beats;
  logic [1:0]    out_beats2;
  logic          out_err;
  logic          out_err2;

  int checks = 0;
  int passed = 0;

  // Reference model: which bit positions were named this frame, beat count and error.
  bit seen [IW];
  int m_beats;
  bit m_err;

  always #5 clk = ~clk;

  dual_priority_decoder #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .BEAT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx1(in_idx1), .in_idx1_v(in_idx1_v), .in_idx2(in_idx2), .in_idx2_v(in_idx2_v),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_beats(out_beats), .out_err(out_err)
  );

  dual_priority_decoder #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .BEAT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_idx1(in_idx1), .in_idx1_v(in_idx1_v), .in_idx2(in_idx2), .in_idx2_v(in_idx2_v),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_mask(out_mask2), .out_beats(out_beats2), .out_err(out_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int k = 0; k < IW; k++) seen[k] = 1'b0;
    m_beats = 0;
    m_err   = 1'b0;
  endtask

  function automatic int model_mask();
    int m = 0;
    for (int k = 0; k < IW; k++) if (seen[k]) m += 2 ** k;
    return m;
  endfunction

  task automatic model_beat(input int i1, input bit v1, input int i2, input bit v2);
    bit e = 1'b0;
    if (v2 && !v1) e = 1'b1;
    if (v1 && v2 && i2 >= i1) e = 1'b1;
    if (v1 && seen[i1]) e = 1'b1;
    if (v2 && seen[i2]) e = 1'b1;
    if (v1) seen[i1] = 1'b1;
    if (v2) seen[i2] = 1'b1;
    m_err = m_err | e;
    m_beats++;
  endtask

  task automatic check_frame(input int hold);
    int exp_mask = model_mask();
    int exp_b    = (m_beats > 255) ? 255 : m_beats;
    int exp_b2   = (m_beats > 3) ? 3 : m_beats;
    logic [IW-1:0] held_mask = out_mask;
    logic [7:0]    held_beats = out_beats;
    logic          held_err  = out_err;
    check("out_valid", out_valid, 1);
    check("out_mask", out_mask, exp_mask);
    check("out_beats", out_beats, exp_b);
    check("out_err", out_err, m_err);
    check("in_ready_hold", in_ready, 0);
    check("sat_out_valid", out_valid2, 1);
    check("sat_out_mask", out_mask2, exp_mask);
    check("sat_out_beats", out_beats2, exp_b2);
    check("sat_out_err", out_err2, m_err);
    out_ready = (hold == 0);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_mask", out_mask, held_mask);
      check("bp_out_beats", out_beats, held_beats);
      check("bp_out_err", out_err, held_err);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    clear_model();
  endtask

  task automatic send_beat(input int i1, input bit v1, input int i2, input bit v2,
                           input bit last, input int hold);
    int n = 0;
    in_idx1   = i1[OW-1:0];
    in_idx1_v = v1;
    in_idx2   = i2[OW-1:0];
    in_idx2_v = v2;
    in_last   = last;
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n > 0) check("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_beat(i1, v1, i2, v2);
    if (last) check_frame(hold);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_idx1   = '0;
    in_idx1_v = 1'b0;
    in_idx2   = '0;
    in_idx2_v = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single beat, then a clean three-beat frame.
    send_beat(6, 1, 3, 1, 1, 0);
    send_beat(7, 1, 5, 1, 0, 0);
    send_beat(4, 1, 2, 1, 0, 0);
    send_beat(0, 1, 0, 0, 1, 0);

    // Ordering error, then duplicate across beats.
    send_beat(2, 1, 5, 1, 1, 0);
    send_beat(3, 1, 1, 1, 0, 0);
    send_beat(3, 1, 0, 0, 1, 0);
    send_beat(4, 0, 1, 1, 1, 0);

    // Consumer stalls for five cycles.
    send_beat(5, 1, 0, 1, 1, 5);

    // Reset mid-frame discards the partial beat.
    send_beat(6, 1, 1, 1, 0, 0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    send_beat(2, 1, 0, 0, 1, 0);

    // Five empty beats saturate the 2-bit counter; a long frame saturates the 8-bit one.
    for (int b = 0; b < 5; b++) send_beat(0, 0, 0, 0, b == 4, 0);
    for (int b = 0; b < 260; b++) send_beat(0, 0, 0, 0, b == 259, 0);

    for (int f = 0; f < 30; f++) begin
      int nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        int i1 = $urandom_range(0, IW - 1);
        int i2 = (i1 > 0 && $urandom_range(0, 3) != 0) ? $urandom_range(0, i1 - 1)
                                                        : $urandom_range(0, IW - 1);
        bit v1 = ($urandom_range(0, 4) != 0);
        bit v2 = ($urandom_range(0, 2) != 0);
        int hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        send_beat(i1, v1, i2, v2, b == nb - 1, hold);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
